mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Target end of the CPU byte-wide memory bus: answers the address/data/write-strobe bus the CPU core drives.
- Contains a byte RAM, a memory-mapped I/O region, a TX FIFO toward the UART transmitter, an RX FIFO from the UART receiver, and a cycle counter.
- Sits between the core and the board UART, and serves as the simulation memory model.
- Read data is returned the cycle after the address is presented; writes complete in one cycle.

Parameters:
- RAM_ADDR_WIDTH, 17, byte-address bits of RAM (2^17 = 128 KB).
- TX_DEPTH_WIDTH, 3, log2 of TX FIFO depth (8 entries).
- RX_DEPTH_WIDTH, 3, log2 of RX FIFO depth.
- INIT_FILE, "test.data", hex image path (used only with the optional feature).

Ports:
- clockIn  input  1  system clock.
- resetIn  input  1  synchronous, active-high reset.
- readyIn  input  1  pause: bus side and counter freeze when low.
- memAddr  input  32  CPU address; only [17:0] is decoded.
- memIn  input  8  CPU write data.
- memWr  input  1  1 = write, 0 = read.
- memOut  output  8  read data, registered.
- ioBufferFull  output  1  TX FIFO near full.
- txValid  output  1  TX FIFO head valid.
- txData  output  8  TX FIFO head byte.
- txReady  input  1  UART accepted head this cycle.
- rxValid  input  1  UART received byte.
- rxData  input  8  received byte.
- rxReady  output  1  RX FIFO not full.
- halted  output  1  program-stop flag, sticky.
- txOverflow  output  1  sticky: a TX write was dropped.

Behaviour:
- Decode: I/O when memAddr[17:16]==2'b11; otherwise RAM index memAddr[RAM_ADDR_WIDTH-1:0].
- Reset values: memOut=0, halted=0, txOverflow=0, both FIFOs empty, counter=0, snapshot=0, prevRead=0.
- readyIn low: no RAM write, no FIFO push/pop from the bus side, memOut held, counter held. TX drain (txReady) and RX fill (rxValid) continue.
- RAM write (memWr=1): byte stored at the clock edge. memOut is held.
- RAM read (memWr=0): memOut <= ram[index] at the next edge (1-cycle latency).
  - Read-after-write to the same address on consecutive cycles returns the new byte.
- I/O 0x30000 write:
  - memIn != 0: push to TX FIFO.
  - memIn == 0: ignored.
  - FIFO full (count==2^TX_DEPTH_WIDTH): byte dropped, txOverflow <= 1.
- I/O 0x30000 read:
  - memOut <= RX head and pop; if RX is empty, memOut <= 0, no pop.
  - A read is "new" only if the previous active cycle was not a read of the same address. Repeated identical read cycles return the same byte without popping again (prevRead/prevAddr registers).
- I/O 0x30004 write: halted <= 1 and push 8'h00 to TX (bypasses the zero filter; dropped with txOverflow if full).
  - After halted=1, all further bus writes (RAM and I/O) are ignored.
- I/O 0x30004..0x30007 read:
  - A new read of 0x30004 latches snapshot <= counter, and memOut <= counter[7:0] the same edge.
  - Reads of 0x30005/6/7 return snapshot[15:8], [23:16], [31:24].
- Other I/O addresses: writes ignored; reads return 0.
- Counter: 32-bit, +1 per cycle with readyIn high and halted=0; wraps 0xFFFFFFFF -> 0.
- TX FIFO:
  - txValid = count!=0; txData = head; pop when txValid && txReady.
  - Simultaneous push and pop: count unchanged; a push is accepted when full only if a pop occurs the same cycle.
  - ioBufferFull = count >= 2^TX_DEPTH_WIDTH - 1, giving one slot of slack for an in-flight write.
- RX FIFO: rxReady = !full; push when rxValid && rxReady. Simultaneous push and pop are both honoured. Pointers wrap modulo depth.
- Reset mid-operation: FIFO contents discarded, pending read data lost. RAM contents are not cleared.

Optional Feature:
- MEM_IO_RAM_INIT_EN defined: RAM preloaded at time zero via $readmemh(INIT_FILE); reset does not alter it.
- Undefined: no initial block; RAM content is X until written. Bench must write before reading.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 next cycle -> memOut==0xA5 exactly one cycle after the read address is presented.
- Write 0x48, 0x00, 0x69 to 0x30000 with txReady=1 -> txData sequence 0x48, 0x69; 0x00 never appears.
- Hold txReady=0, write 9 nonzero bytes to 0x30000 -> ioBufferFull rises after the 7th; 9th dropped; txOverflow=1; exactly 8 bytes drained afterward.
- Push rxData 0x31, 0x32; read 0x30000 for 3 consecutive identical cycles, then 0x00000, then 0x30000 -> memOut 0x31, then 0x32; third read returns 0x00 (empty).
- After 100 active cycles from reset, read 0x30004..0x30007 -> the assembled bytes equal the latched counter (~100); a re-read of 0x30005 still returns the snapshot byte.
- Write any byte to 0x30004 -> halted=1, TX emits 0x00, counter stops; a later RAM write to 0x00010 leaves its old value.

Source files
------------

// File: rtl/mem_io_responder.sv
// mem_io_responder: target end of the CPU byte-wide memory bus.
// Byte RAM, memory-mapped I/O (UART TX/RX FIFOs, cycle counter, halt flag).
// Read data is registered (one-cycle latency); writes complete in one cycle.
// The RAM starts undefined until written.
module mem_io_responder #(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int TX_DEPTH_WIDTH = 3,
   parameter int RX_DEPTH_WIDTH = 3,
   parameter     INIT_FILE      = "test.data"
) (
   input  logic        clockIn,
   input  logic        resetIn,
   input  logic        readyIn,
   input  logic [31:0] memAddr,
   input  logic [7:0]  memIn,
   input  logic        memWr,
   output logic [7:0]  memOut,
   output logic        ioBufferFull,
   output logic        txValid,
   output logic [7:0]  txData,
   input  logic        txReady,
   input  logic        rxValid,
   input  logic [7:0]  rxData,
   output logic        rxReady,
   output logic        halted,
   output logic        txOverflow
);

   localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;
   localparam int TX_DEPTH  = 1 << TX_DEPTH_WIDTH;
   localparam int RX_DEPTH  = 1 << RX_DEPTH_WIDTH;

   localparam logic [TX_DEPTH_WIDTH:0] C_TX_FULL  = {1'b1, {TX_DEPTH_WIDTH{1'b0}}};
   // One slot of slack so a write already in flight still fits.
   localparam logic [TX_DEPTH_WIDTH:0] C_TX_AFULL = {1'b0, {TX_DEPTH_WIDTH{1'b1}}};
   localparam logic [RX_DEPTH_WIDTH:0] C_RX_FULL  = {1'b1, {RX_DEPTH_WIDTH{1'b0}}};

   localparam logic [17:0] C_IO_DATA = 18'h30000;
   localparam logic [17:0] C_IO_CNT0 = 18'h30004;
   localparam logic [17:0] C_IO_CNT1 = 18'h30005;
   localparam logic [17:0] C_IO_CNT2 = 18'h30006;
   localparam logic [17:0] C_IO_CNT3 = 18'h30007;

   // ---------------------------------------------------------------------
   // Storage and state
   // ---------------------------------------------------------------------
   logic [7:0]                r_ram [RAM_DEPTH];

   logic [7:0]                r_tx_mem [TX_DEPTH];
   logic [TX_DEPTH_WIDTH-1:0] r_tx_wp;
   logic [TX_DEPTH_WIDTH-1:0] r_tx_rp;
   logic [TX_DEPTH_WIDTH:0]   r_tx_cnt;

   logic [7:0]                r_rx_mem [RX_DEPTH];
   logic [RX_DEPTH_WIDTH-1:0] r_rx_wp;
   logic [RX_DEPTH_WIDTH-1:0] r_rx_rp;
   logic [RX_DEPTH_WIDTH:0]   r_rx_cnt;

   logic [7:0]                r_mem_out;
   logic [31:0]               r_cnt;
   logic [31:0]               r_snap;
   logic                      r_halted;
   logic                      r_tx_ovf;
   logic                      r_prev_rd;
   logic [17:0]               r_prev_addr;

   // ---------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------
   logic [17:0]               w_addr;
   logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;
   logic                      w_is_io;
   logic                      w_bus_wr;
   logic                      w_bus_rd;
   logic                      w_new_rd;
   logic                      w_ram_we;
   logic                      w_halt_set;
   logic                      w_unused_addr;

   assign w_addr        = memAddr[17:0];
   assign w_ram_idx     = memAddr[RAM_ADDR_WIDTH-1:0];
   assign w_is_io       = (w_addr[17:16] == 2'b11);
   assign w_unused_addr = ^memAddr[31:18];

   // Once halted, the bus can no longer modify anything.
   assign w_bus_wr   = readyIn && memWr && !r_halted;
   assign w_bus_rd   = readyIn && !memWr;
   // Holding the same read for several cycles must not pop/latch repeatedly.
   assign w_new_rd   = !(r_prev_rd && (r_prev_addr == w_addr));
   assign w_ram_we   = w_bus_wr && !w_is_io && !resetIn;
   assign w_halt_set = w_bus_wr && (w_addr == C_IO_CNT0);

   // ---------------------------------------------------------------------
   // TX FIFO control
   // ---------------------------------------------------------------------
   logic       w_tx_full;
   logic       w_tx_pop;
   logic       w_tx_push_req;
   logic       w_tx_push;
   logic [7:0] w_tx_push_data;

   assign w_tx_full      = (r_tx_cnt == C_TX_FULL);
   assign w_tx_pop       = (r_tx_cnt != '0) && txReady;
   // The halt write always emits a 0x00 terminator; data writes of 0 are dropped.
   assign w_tx_push_req  = w_bus_wr &&
                           (((w_addr == C_IO_DATA) && (memIn != 8'h00)) ||
                            (w_addr == C_IO_CNT0));
   assign w_tx_push_data = (w_addr == C_IO_CNT0) ? 8'h00 : memIn;
   // A full FIFO still accepts a byte when the head leaves the same cycle.
   assign w_tx_push      = w_tx_push_req && (!w_tx_full || w_tx_pop);

   assign txValid      = (r_tx_cnt != '0);
   assign txData       = r_tx_mem[r_tx_rp];
   assign ioBufferFull = (r_tx_cnt >= C_TX_AFULL);
   assign txOverflow   = r_tx_ovf;

   // ---------------------------------------------------------------------
   // RX FIFO control
   // ---------------------------------------------------------------------
   logic w_rx_full;
   logic w_rx_empty;
   logic w_rx_push;
   logic w_rx_pop;

   assign w_rx_full  = (r_rx_cnt == C_RX_FULL);
   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_rx_push  = rxValid && !w_rx_full;
   assign w_rx_pop   = w_bus_rd && (w_addr == C_IO_DATA) && w_new_rd && !w_rx_empty;

   assign rxReady = !w_rx_full;
   assign memOut  = r_mem_out;
   assign halted  = r_halted;

   // ---------------------------------------------------------------------
   // RAM
   // ---------------------------------------------------------------------
   localparam int unused_init_bits = $bits(INIT_FILE);

   // RAM byte write; no reset so contents survive a reset.
   always_ff @(posedge clockIn) begin
      if (w_ram_we)
         r_ram[w_ram_idx] <= memIn;
   end

   // ---------------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------------
   // TX data storage.
   always_ff @(posedge clockIn) begin
      if (w_tx_push)
         r_tx_mem[r_tx_wp] <= w_tx_push_data;
   end

   // TX pointers and occupancy.
   always_ff @(posedge clockIn) begin
      if (resetIn) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_tx_push)
            r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_pop)
            r_tx_rp <= r_tx_rp + 1'b1;
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
            2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
            default: r_tx_cnt <= r_tx_cnt;
         endcase
      end
   end

   // Sticky flag: a TX byte was dropped because the FIFO was full.
   always_ff @(posedge clockIn) begin
      if (resetIn)
         r_tx_ovf <= 1'b0;
      else if (w_tx_push_req && w_tx_full && !w_tx_pop)
         r_tx_ovf <= 1'b1;
   end

   // ---------------------------------------------------------------------
   // RX FIFO
   // ---------------------------------------------------------------------
   // RX data storage.
   always_ff @(posedge clockIn) begin
      if (w_rx_push)
         r_rx_mem[r_rx_wp] <= rxData;
   end

   // RX pointers and occupancy.
   always_ff @(posedge clockIn) begin
      if (resetIn) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else begin
         if (w_rx_push)
            r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop)
            r_rx_rp <= r_rx_rp + 1'b1;
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
            2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
            default: r_rx_cnt <= r_rx_cnt;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Control registers
   // ---------------------------------------------------------------------
   // Free-running cycle counter, frozen by pause or halt.
   always_ff @(posedge clockIn) begin
      if (resetIn)
         r_cnt <= '0;
      else if (readyIn && !r_halted)
         r_cnt <= r_cnt + 32'd1;
   end

   // Sticky program-stop flag.
   always_ff @(posedge clockIn) begin
      if (resetIn)
         r_halted <= 1'b0;
      else if (w_halt_set)
         r_halted <= 1'b1;
   end

   // Remember the last active bus cycle to detect repeated reads.
   always_ff @(posedge clockIn) begin
      if (resetIn) begin
         r_prev_rd   <= 1'b0;
         r_prev_addr <= '0;
      end else if (readyIn) begin
         r_prev_rd   <= !memWr;
         r_prev_addr <= w_addr;
      end
   end

   // Registered read data and counter snapshot.
   always_ff @(posedge clockIn) begin
      if (resetIn) begin
         r_mem_out <= 8'h00;
         r_snap    <= '0;
      end else if (w_bus_rd) begin
         if (!w_is_io) begin
            r_mem_out <= r_ram[w_ram_idx];
         end else begin
            case (w_addr)
               C_IO_DATA: begin
                  if (w_new_rd)
                     r_mem_out <= w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
               end
               C_IO_CNT0: begin
                  if (w_new_rd) begin
                     r_snap    <= r_cnt;
                     r_mem_out <= r_cnt[7:0];
                  end
               end
               C_IO_CNT1: r_mem_out <= r_snap[15:8];
               C_IO_CNT2: r_mem_out <= r_snap[23:16];
               C_IO_CNT3: r_mem_out <= r_snap[31:24];
               default:   r_mem_out <= 8'h00;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed scenarios plus a
// randomized run against a queue-based transaction model.
module tb_mem_io_responder;

   logic        clk;
   logic        rst, rdy, wr, txr, rxv;
   logic [31:0] addr;
   logic [7:0]  din, rxd;
   logic [7:0]  memOut, txData;
   logic        ioBufferFull, txValid, rxReady, halted, txOverflow;

   mem_io_responder dut (
      .clockIn(clk), .resetIn(rst), .readyIn(rdy),
      .memAddr(addr), .memIn(din), .memWr(wr), .memOut(memOut),
      .ioBufferFull(ioBufferFull), .txValid(txValid), .txData(txData),
      .txReady(txr), .rxValid(rxv), .rxData(rxd), .rxReady(rxReady),
      .halted(halted), .txOverflow(txOverflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass;
   int n_total;

   // Reference model state
   logic [7:0]  m_ram [logic [16:0]];
   logic [7:0]  m_txq[$];
   logic [7:0]  m_rxq[$];
   logic [7:0]  dut_drained[$];
   logic [7:0]  m_out;
   logic        m_known, m_halt, m_ovf, m_prev_rd;
   logic [17:0] m_prev_addr;
   logic [31:0] m_cnt, m_snap;

   task automatic tx_push(input logic [7:0] b);
      if (m_txq.size() >= 8) m_ovf = 1'b1;
      else m_txq.push_back(b);
   endtask

   // Apply one clock edge's worth of behaviour to the model.
   task automatic model_edge();
      logic        tx_pop, rx_push, rx_pop, halt_now, newrd;
      logic [17:0] a;
      if (rst) begin
         m_txq.delete(); m_rxq.delete();
         m_out = 8'h00; m_known = 1'b1; m_halt = 1'b0; m_ovf = 1'b0;
         m_cnt = 0; m_snap = 0; m_prev_rd = 1'b0; m_prev_addr = '0;
         return;
      end
      tx_pop   = (m_txq.size() != 0) && txr;
      rx_push  = rxv && (m_rxq.size() < 8);
      rx_pop   = 1'b0;
      halt_now = 1'b0;
      if (tx_pop) void'(m_txq.pop_front());
      if (rdy) begin
         a = addr[17:0];
         newrd = !(m_prev_rd && (m_prev_addr == a));
         if (wr) begin
            if (!m_halt) begin
               if (a[17:16] != 2'b11) m_ram[a[16:0]] = din;
               else if (a == 18'h30000 && din != 8'h00) tx_push(din);
               else if (a == 18'h30004) begin halt_now = 1'b1; tx_push(8'h00); end
            end
         end else if (a[17:16] != 2'b11) begin
            if (m_ram.exists(a[16:0])) begin m_out = m_ram[a[16:0]]; m_known = 1'b1; end
            else m_known = 1'b0;
         end else begin
            case (a)
               18'h30000: if (newrd) begin
                  m_known = 1'b1;
                  if (m_rxq.size() != 0) begin m_out = m_rxq[0]; rx_pop = 1'b1; end
                  else m_out = 8'h00;
               end
               18'h30004: if (newrd) begin m_snap = m_cnt; m_out = m_cnt[7:0]; m_known = 1'b1; end
               18'h30005: begin m_out = m_snap[15:8];  m_known = 1'b1; end
               18'h30006: begin m_out = m_snap[23:16]; m_known = 1'b1; end
               18'h30007: begin m_out = m_snap[31:24]; m_known = 1'b1; end
               default:   begin m_out = 8'h00; m_known = 1'b1; end
            endcase
         end
         m_prev_rd = !wr; m_prev_addr = a;
      end
      if (rx_pop) void'(m_rxq.pop_front());
      if (rx_push) m_rxq.push_back(rxd);
      if (rdy && !m_halt) m_cnt = m_cnt + 1;
      if (halt_now) m_halt = 1'b1;
   endtask

   task automatic set_bus(input logic [31:0] a, input logic w, input logic [7:0] d);
      addr = a; wr = w; din = d;
   endtask

   // One clock: log drained TX bytes, take the edge, update model, settle.
   task automatic cyc();
      if (txValid === 1'b1 && txr === 1'b1) dut_drained.push_back(txData);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; set_bus(32'h10, 1'b0, 8'h00);
      cyc(); cyc();
      n_total++; if (memOut !== 8'h00) $display("FAIL reset_memOut got %h exp 00", memOut); else n_pass++;
      n_total++; if (txValid !== 1'b0) $display("FAIL reset_txValid got %b exp 0", txValid); else n_pass++;
      n_total++; if (ioBufferFull !== 1'b0) $display("FAIL reset_ioBufferFull got %b exp 0", ioBufferFull); else n_pass++;
      n_total++; if (rxReady !== 1'b1) $display("FAIL reset_rxReady got %b exp 1", rxReady); else n_pass++;
      n_total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted); else n_pass++;
      n_total++; if (txOverflow !== 1'b0) $display("FAIL reset_txOverflow got %b exp 0", txOverflow); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_ram_raw();
      set_bus(32'h10, 1'b1, 8'hA5); cyc();
      n_total++; if (memOut !== 8'h00) $display("FAIL ram_hold_on_write got %h exp 00", memOut); else n_pass++;
      set_bus(32'h10, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== 8'hA5) $display("FAIL ram_raw got %h exp a5", memOut); else n_pass++;
      set_bus(32'h1FFFF, 1'b1, 8'hC3); cyc();
      set_bus(32'h1FFFF, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== 8'hC3) $display("FAIL ram_top got %h exp c3", memOut); else n_pass++;
      set_bus(32'h11, 1'b1, 8'h7E); cyc();
      set_bus(32'h11, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== 8'h7E) $display("FAIL ram_raw2 got %h exp 7e", memOut); else n_pass++;
      set_bus(32'hFFFC0010, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== 8'hA5) $display("FAIL ram_upper_bits got %h exp a5", memOut); else n_pass++;
      // Paused cycles: no write, memOut held.
      rdy = 1'b0; set_bus(32'h10, 1'b1, 8'h11); cyc();
      set_bus(32'h11, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== 8'hA5) $display("FAIL pause_hold got %h exp a5", memOut); else n_pass++;
      rdy = 1'b1; set_bus(32'h10, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== 8'hA5) $display("FAIL pause_no_write got %h exp a5", memOut); else n_pass++;
   endtask

   task automatic test_tx_filter();
      txr = 1'b1; dut_drained.delete();
      set_bus(32'h30000, 1'b1, 8'h48); cyc();
      set_bus(32'h30000, 1'b1, 8'h00); cyc();
      set_bus(32'h30000, 1'b1, 8'h69); cyc();
      set_bus(32'h10, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) cyc();
      n_total++; if (dut_drained.size() != 2) $display("FAIL tx_filter_count got %0d exp 2", dut_drained.size()); else n_pass++;
      n_total++; if (dut_drained.size() < 1 || dut_drained[0] !== 8'h48) $display("FAIL tx_filter_b0 got size %0d exp 48", dut_drained.size()); else n_pass++;
      n_total++; if (dut_drained.size() < 2 || dut_drained[1] !== 8'h69) $display("FAIL tx_filter_b1 got size %0d exp 69", dut_drained.size()); else n_pass++;
      txr = 1'b0;
   endtask

   task automatic test_tx_overflow();
      txr = 1'b0;
      for (int i = 0; i < 9; i++) begin
         set_bus(32'h30000, 1'b1, 8'(8'h41 + i)); cyc();
         if (i == 5) begin n_total++; if (ioBufferFull !== 1'b0) $display("FAIL afull_after6 got %b exp 0", ioBufferFull); else n_pass++; end
         if (i == 6) begin n_total++; if (ioBufferFull !== 1'b1) $display("FAIL afull_after7 got %b exp 1", ioBufferFull); else n_pass++; end
         if (i == 7) begin n_total++; if (txOverflow !== 1'b0) $display("FAIL ovf_after8 got %b exp 0", txOverflow); else n_pass++; end
         if (i == 8) begin n_total++; if (txOverflow !== 1'b1) $display("FAIL ovf_after9 got %b exp 1", txOverflow); else n_pass++; end
      end
      set_bus(32'h10, 1'b0, 8'h00); txr = 1'b1; dut_drained.delete();
      for (int i = 0; i < 12; i++) cyc();
      n_total++; if (dut_drained.size() != 8) $display("FAIL ovf_drain_count got %0d exp 8", dut_drained.size()); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_total++;
         if (dut_drained.size() <= i || dut_drained[i] !== 8'(8'h41 + i))
            $display("FAIL ovf_drain_byte%0d size %0d exp %h", i, dut_drained.size(), 8'(8'h41 + i));
         else n_pass++;
      end
      n_total++; if (txOverflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", txOverflow); else n_pass++;
      n_total++; if (ioBufferFull !== 1'b0) $display("FAIL afull_cleared got %b exp 0", ioBufferFull); else n_pass++;
      txr = 1'b0;
   endtask

   task automatic test_rx();
      set_bus(32'h0, 1'b1, 8'h5A); cyc();
      set_bus(32'h10, 1'b0, 8'h00);
      rxv = 1'b1; rxd = 8'h31; cyc(); rxd = 8'h32; cyc(); rxv = 1'b0;
      set_bus(32'h30000, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_total++; if (memOut !== 8'h31) $display("FAIL rx_repeat%0d got %h exp 31", i, memOut); else n_pass++;
      end
      set_bus(32'h0, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== 8'h5A) $display("FAIL rx_ram0 got %h exp 5a", memOut); else n_pass++;
      set_bus(32'h30000, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== 8'h32) $display("FAIL rx_second got %h exp 32", memOut); else n_pass++;
      set_bus(32'h0, 1'b0, 8'h00); cyc();
      set_bus(32'h30000, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== 8'h00) $display("FAIL rx_empty got %h exp 00", memOut); else n_pass++;
      // Fill to capacity; the ninth byte is refused.
      set_bus(32'h10, 1'b0, 8'h00); rxv = 1'b1;
      for (int i = 0; i < 9; i++) begin rxd = 8'(8'h80 + i); cyc(); end
      rxv = 1'b0;
      n_total++; if (rxReady !== 1'b0) $display("FAIL rx_full got %b exp 0", rxReady); else n_pass++;
      for (int i = 0; i < 9; i++) begin
         set_bus(32'h30000, 1'b0, 8'h00); cyc();
         n_total++;
         if (memOut !== ((i < 8) ? 8'(8'h80 + i) : 8'h00))
            $display("FAIL rx_drain%0d got %h exp %h", i, memOut, (i < 8) ? 8'(8'h80 + i) : 8'h00);
         else n_pass++;
         set_bus(32'h10, 1'b0, 8'h00); cyc();
      end
      n_total++; if (rxReady !== 1'b1) $display("FAIL rx_ready_again got %b exp 1", rxReady); else n_pass++;
   endtask

   task automatic test_counter();
      set_bus(32'h10, 1'b0, 8'h00);
      rst = 1'b1; cyc(); cyc(); rst = 1'b0;
      n_total++; if (memOut !== 8'h00) $display("FAIL cnt_reset_memOut got %h exp 00", memOut); else n_pass++;
      for (int i = 0; i < 105; i++) begin
         rdy = !(i >= 50 && i < 55);
         cyc();
      end
      rdy = 1'b1;
      set_bus(32'h30004, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== 8'h64) $display("FAIL cnt_b0 got %h exp 64", memOut); else n_pass++;
      cyc();
      n_total++; if (memOut !== 8'h64) $display("FAIL cnt_repeat got %h exp 64", memOut); else n_pass++;
      for (int k = 5; k < 8; k++) begin
         set_bus(32'h30000 + k, 1'b0, 8'h00); cyc();
         n_total++; if (memOut !== 8'h00) $display("FAIL cnt_b%0d got %h exp 00", k - 4, memOut); else n_pass++;
      end
      set_bus(32'h30005, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== 8'h00) $display("FAIL cnt_reread got %h exp 00", memOut); else n_pass++;
      set_bus(32'h10, 1'b0, 8'h00);
      for (int i = 0; i < 200; i++) cyc();
      set_bus(32'h30004, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== 8'h32) $display("FAIL cnt2_b0 got %h exp 32", memOut); else n_pass++;
      set_bus(32'h30005, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== 8'h01) $display("FAIL cnt2_b1 got %h exp 01", memOut); else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic        w;
      rdy = 1'b1; txr = 1'b0; rxv = 1'b0;
      for (int k = 0; k < 8; k++) begin set_bus(32'h100 + k, 1'b1, 8'($urandom)); cyc(); end
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 249) == 0);
         rdy = ($urandom_range(0, 99) < 85);
         txr = 1'($urandom_range(0, 1));
         rxv = ($urandom_range(0, 99) < 40);
         rxd = 8'($urandom);
         if ($urandom_range(0, 99) >= 30) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3: a = 32'h100 + $urandom_range(0, 7);
               4, 5, 6:    a = 32'h30000;
               7:          a = 32'h30004 + $urandom_range(0, 3);
               default:    a = 32'h30010 + $urandom_range(0, 3);
            endcase
            a[31:18] = 14'($urandom);
            w = ($urandom_range(0, 99) < 40);
            if (a[17:0] == 18'h30004) w = 1'b0;
            set_bus(a, w, ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom));
         end
         cyc();
         if (m_known) begin
            n_total++; if (memOut !== m_out) $display("FAIL rnd_memOut cyc %0d got %h exp %h", n, memOut, m_out); else n_pass++;
         end
         n_total++; if (txValid !== (m_txq.size() != 0)) $display("FAIL rnd_txValid cyc %0d got %b exp %b", n, txValid, m_txq.size() != 0); else n_pass++;
         if (m_txq.size() != 0) begin
            n_total++; if (txData !== m_txq[0]) $display("FAIL rnd_txData cyc %0d got %h exp %h", n, txData, m_txq[0]); else n_pass++;
         end
         n_total++; if (ioBufferFull !== (m_txq.size() >= 7)) $display("FAIL rnd_ioBufferFull cyc %0d got %b exp %b", n, ioBufferFull, m_txq.size() >= 7); else n_pass++;
         n_total++; if (rxReady !== (m_rxq.size() < 8)) $display("FAIL rnd_rxReady cyc %0d got %b exp %b", n, rxReady, m_rxq.size() < 8); else n_pass++;
         n_total++; if (txOverflow !== m_ovf) $display("FAIL rnd_txOverflow cyc %0d got %b exp %b", n, txOverflow, m_ovf); else n_pass++;
         n_total++; if (halted !== m_halt) $display("FAIL rnd_halted cyc %0d got %b exp %b", n, halted, m_halt); else n_pass++;
      end
      rst = 1'b0; rdy = 1'b1; rxv = 1'b0; txr = 1'b0;
   endtask

   task automatic test_halt();
      logic [31:0] hc;
      txr = 1'b1; set_bus(32'h10, 1'b0, 8'h00);
      for (int i = 0; i < 12; i++) cyc();
      set_bus(32'h10, 1'b1, 8'h3C); cyc();
      dut_drained.delete();
      set_bus(32'h30004, 1'b1, 8'h77); cyc();
      hc = m_cnt;
      n_total++; if (halted !== 1'b1) $display("FAIL halt_flag got %b exp 1", halted); else n_pass++;
      set_bus(32'h10, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) cyc();
      n_total++; if (dut_drained.size() != 1 || dut_drained[0] !== 8'h00) $display("FAIL halt_tx_zero size %0d exp 1 byte 00", dut_drained.size()); else n_pass++;
      set_bus(32'h10, 1'b1, 8'hFF); cyc();
      set_bus(32'h10, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== 8'h3C) $display("FAIL halt_ram_locked got %h exp 3c", memOut); else n_pass++;
      set_bus(32'h30000, 1'b1, 8'h55); cyc();
      set_bus(32'h10, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) cyc();
      n_total++; if (txValid !== 1'b0 || dut_drained.size() != 1) $display("FAIL halt_tx_locked txValid %b drained %0d exp 0/1", txValid, dut_drained.size()); else n_pass++;
      set_bus(32'h30004, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== hc[7:0]) $display("FAIL halt_cnt_a got %h exp %h", memOut, hc[7:0]); else n_pass++;
      set_bus(32'h10, 1'b0, 8'h00);
      for (int i = 0; i < 10; i++) cyc();
      set_bus(32'h30005, 1'b0, 8'h00); cyc();
      set_bus(32'h30004, 1'b0, 8'h00); cyc();
      n_total++; if (memOut !== hc[7:0]) $display("FAIL halt_cnt_frozen got %h exp %h", memOut, hc[7:0]); else n_pass++;
      n_total++; if (halted !== 1'b1) $display("FAIL halt_sticky got %b exp 1", halted); else n_pass++;
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst = 1'b1; rdy = 1'b1; addr = 32'h10; wr = 1'b0; din = 8'h00;
      txr = 1'b0; rxv = 1'b0; rxd = 8'h00;
      m_out = 8'h00; m_known = 1'b0; m_halt = 1'b0; m_ovf = 1'b0;
      m_prev_rd = 1'b0; m_prev_addr = '0; m_cnt = 0; m_snap = 0;
      #1;
      test_reset();
      test_ram_raw();
      test_tx_filter();
      test_tx_overflow();
      test_rx();
      test_counter();
      test_random();
      test_halt();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
